// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler tick.
// Supports wrap or saturate at terminal count, and a parallel load that rejects non-BCD digits.
module bcd_counter_n #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned DIV      = 50000000,
   parameter int unsigned SATURATE = 0
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   q,
   output logic                  step,
   output logic                  tc,
   output logic                  load_err
);

   localparam int unsigned W        = 4 * DIGITS;
   localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div;
   logic [W-1:0]     stepped;
   logic [W-1:0]     load_val;
   logic             load_bad;
   logic             wrapped;
   logic             carry;
   logic [3:0]       digit;

   // Carry/borrow ripples from digit 0; a carry out of the top digit marks terminal count.
   always_comb begin
      stepped = q;
      carry   = 1'b1;
      digit   = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         digit = q[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (digit == 4'd9) begin
                  stepped[4*i +: 4] = 4'd0;
               end else begin
                  stepped[4*i +: 4] = digit + 4'd1;
                  carry             = 1'b0;
               end
            end else begin
               if (digit == 4'd0) begin
                  stepped[4*i +: 4] = 4'd9;
               end else begin
                  stepped[4*i +: 4] = digit - 4'd1;
                  carry             = 1'b0;
               end
            end
         end
      end
      wrapped = carry;
      if (wrapped && (SATURATE != 0)) begin
         stepped = q;
      end
   end

   always_comb begin
      load_val = '0;
      load_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (din[4*i +: 4] > 4'd9) begin
            load_bad = 1'b1;
         end else begin
            load_val[4*i +: 4] = din[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q        <= '0;
         div      <= '0;
         step     <= 1'b0;
         tc       <= 1'b0;
         load_err <= 1'b0;
      end else begin
         step     <= 1'b0;
         tc       <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            q        <= load_val;
            load_err <= load_bad;
            div      <= '0;
         end else if (en) begin
            if (div == DIV_LAST) begin
               div  <= '0;
               q    <= stepped;
               step <= 1'b1;
               tc   <= wrapped;
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: three 2-digit instances (DIV=3 wrap, DIV=1 wrap, DIV=1 saturate)
// share stimulus and are compared each cycle against a decimal-integer reference model.
module tb_bcd_counter_n;

   localparam int NI  = 3;
   localparam int TOP = 99;

   logic       clk  = 1'b0;
   logic       clr  = 1'b0;
   logic       en   = 1'b0;
   logic       up   = 1'b1;
   logic       load = 1'b0;
   logic [7:0] din  = 8'h00;

   logic [7:0] dq    [NI];
   logic       dstep [NI];
   logic       dtc   [NI];
   logic       derr  [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      bcd_counter_n #(
         .DIGITS  (2),
         .DIV     ((k == 0) ? 3 : 1),
         .SATURATE((k == 2) ? 1 : 0)
      ) u_dut (
         .clk     (clk),
         .clr     (clr),
         .en      (en),
         .up      (up),
         .load    (load),
         .din     (din),
         .q       (dq[k]),
         .step    (dstep[k]),
         .tc      (dtc[k]),
         .load_err(derr[k])
      );
   end

   // Reference model: count held as a plain decimal integer 0..99.
   int mval [NI] = '{0, 0, 0};
   int mdiv [NI] = '{0, 0, 0};
   bit mstep[NI] = '{0, 0, 0};
   bit mtc  [NI] = '{0, 0, 0};
   bit merr [NI] = '{0, 0, 0};

   function automatic int div_of(int k);
      return (k == 0) ? 3 : 1;
   endfunction

   always @(posedge clk or posedge clr) begin
      int hi;
      int lo;
      for (int k = 0; k < NI; k++) begin
         mstep[k] = 1'b0;
         mtc[k]   = 1'b0;
         merr[k]  = 1'b0;
         if (clr) begin
            mval[k] = 0;
            mdiv[k] = 0;
         end else if (load) begin
            hi = int'(din[7:4]);
            lo = int'(din[3:0]);
            if (hi > 9) begin hi = 0; merr[k] = 1'b1; end
            if (lo > 9) begin lo = 0; merr[k] = 1'b1; end
            mval[k] = hi * 10 + lo;
            mdiv[k] = 0;
         end else if (en) begin
            if (mdiv[k] == div_of(k) - 1) begin
               mdiv[k]  = 0;
               mstep[k] = 1'b1;
               if (up) begin
                  if (mval[k] == TOP) begin
                     mtc[k]  = 1'b1;
                     mval[k] = (k == 2) ? TOP : 0;
                  end else begin
                     mval[k] = mval[k] + 1;
                  end
               end else begin
                  if (mval[k] == 0) begin
                     mtc[k]  = 1'b1;
                     mval[k] = (k == 2) ? 0 : TOP;
                  end else begin
                     mval[k] = mval[k] - 1;
                  end
               end
            end else begin
               mdiv[k] = mdiv[k] + 1;
            end
         end
      end
   end

   function automatic logic [10:0] mexp(int k);
      logic [7:0] b;
      b = {4'(mval[k] / 10), 4'(mval[k] % 10)};
      return {b, mstep[k], mtc[k], merr[k]};
   endfunction

   function automatic logic [10:0] act(int k);
      return {dq[k], dstep[k], dtc[k], derr[k]};
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== 11'd0) begin
               n_bad++;
               $display("FAIL reset c%0d inst%0d actual={q,step,tc,err}=%h expected=000", c, k, act(k));
            end
         end
      end
      clr = 1'b0;
   endtask

   task automatic test_count_up();
      en = 1'b1;
      up = 1'b1;
      for (int c = 0; c < 910; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL count_up c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_count_down();
      @(negedge clk);
      load = 1'b1; din = 8'h10; up = 1'b0; en = 1'b1;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (c == 0) begin
            n_cmp++;
            if (dq[1] !== 8'h10 || dstep[1] !== 1'b0) begin
               n_bad++;
               $display("FAIL down_load actual q=%h step=%b expected q=10 step=0", dq[1], dstep[1]);
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL count_down c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_saturate();
      @(negedge clk);
      load = 1'b1; din = 8'h98; up = 1'b1; en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (c == 2) begin
            n_cmp++;
            if (dq[2] !== 8'h99 || dtc[2] !== 1'b1) begin
               n_bad++;
               $display("FAIL sat_hold actual q=%h tc=%b expected q=99 tc=1", dq[2], dtc[2]);
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL saturate c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
         if (c == 5) begin
            load = 1'b1; din = 8'h00; up = 1'b0;
         end
      end
   endtask

   task automatic test_load_err();
      @(negedge clk);
      en = 1'b0; load = 1'b1; din = 8'h3C;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (dq[k] !== 8'h30 || derr[k] !== (c == 0)) begin
               n_bad++;
               $display("FAIL load_err c%0d inst%0d actual q=%h err=%b expected q=30 err=%b", c, k, dq[k], derr[k], c == 0);
            end
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL load_err_model c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_load_vs_step();
      @(negedge clk);
      load = 1'b1; din = 8'h05; en = 1'b1; up = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         load = (c == 3);
         din  = 8'h50;
         if (c == 4 || c == 7) begin
            n_cmp++;
            if (dq[0] !== ((c == 4) ? 8'h50 : 8'h51) || dstep[0] !== (c == 7)) begin
               n_bad++;
               $display("FAIL load_wins c%0d actual q=%h step=%b", c, dq[0], dstep[0]);
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL load_vs_step c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_enable_freeze();
      @(negedge clk);
      load = 1'b1; din = 8'h20; en = 1'b1; up = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         load = 1'b0;
         en   = !(c >= 2 && c <= 6);
         if (c >= 3) begin
            n_cmp++;
            if (dq[0] !== ((c == 9) ? 8'h21 : 8'h20) || dstep[0] !== (c == 9)) begin
               n_bad++;
               $display("FAIL freeze c%0d actual q=%h step=%b expected q=%s", c, dq[0], dstep[0], (c == 9) ? "21" : "20");
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL enable_freeze c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_async_clear();
      @(negedge clk);
      load = 1'b1; din = 8'h47; en = 1'b0; up = 1'b1;
      @(negedge clk);
      load = 1'b0; en = 1'b1;
      @(posedge clk);
      #2 clr = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         n_cmp++;
         if (act(k) !== 11'd0) begin
            n_bad++;
            $display("FAIL async_clr inst%0d actual=%h expected=000", k, act(k));
         end
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 3) begin
            n_cmp++;
            if (dq[0] !== 8'h01 || dstep[0] !== 1'b1) begin
               n_bad++;
               $display("FAIL clr_first_step actual q=%h step=%b expected q=01 step=1", dq[0], dstep[0]);
            end
         end
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL async_clear c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (act(k) !== mexp(k)) begin
               n_bad++;
               $display("FAIL random c%0d inst%0d actual=%h expected=%h", c, k, act(k), mexp(k));
            end
         end
         en   = ($urandom_range(3, 0) != 0);
         if ($urandom_range(40, 0) == 0) up = ~up;
         load = ($urandom_range(15, 0) == 0);
         din  = 8'($urandom);
      end
   endtask

   initial begin
      #1 clr = 1'b1;
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_load_err();
      test_load_vs_step();
      test_enable_freeze();
      test_async_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
